serializer: RTL
===============

# serializer

Transmit-side partner of the link deserializer. Accepts {address, data} words from local logic into a small FIFO and shifts each one out MSB-first as a 19-bit frame on a generated serial clock. A load strobe is aligned with the last bit so the receiver's shift register and enable update on the same edge. A trailing bit then clears the receiver's enable.

## Interface
Parameters:
- ADDR_W, 3, address field width.
- DATA_W, 16, data field width. Frame width FRAME_W = ADDR_W+DATA_W = 19.
- CLK_DIV, 2, half-period of TX_CLK in CLK cycles; ≥1.
- GAP_CYC, 4, idle CLK cycles between frames; ≥0.
- DEPTH, 4, FIFO entries; power of two.

Ports:
- CLK  in  1  system clock. One clock for the whole block.
- RST  in  1  synchronous, active-high reset.
- P_ADDR  in  ADDR_W  word address.
- P_DATA  in  DATA_W  word data.
- P_WR  in  1  write strobe, one word per high CLK cycle.
- P_FULL  out  1  FIFO full (registered count == DEPTH).
- OVERFLOW  out  1  sticky; set by a write while full; cleared only by RST.
- TX_CLK  out  1  serial clock, idles low.
- TX_DATA  out  1  serial data, MSB (address bit 2) first.
- TX_LOAD  out  1  high for the whole period of frame bit 18 (last data bit).
- TX_STOP  out  1  high for the whole trailer period.
- BUSY  out  1  high in any state other than IDLE.

## Operation
- FIFO behaviour:
  - A write when P_FULL=0 stores {P_ADDR,P_DATA}.
  - A write when P_FULL=1 is dropped and sets OVERFLOW. This holds even if a pop occurs in the same cycle.
  - A simultaneous write and pop while not full leaves the count unchanged.
  - Read and write pointers wrap modulo DEPTH.
- State machine: IDLE → SHIFT → TRAIL → GAP → IDLE.
  - IDLE: TX_CLK=0, TX_DATA=0, TX_LOAD=0, TX_STOP=0. When the FIFO is non-empty, pop one entry into the 19-bit shift register, clear the bit counter and go to SHIFT. There is no write-to-pop bypass; the FIFO is always used.
  - SHIFT: each bit period is CLK_DIV cycles with TX_CLK low, then CLK_DIV cycles with TX_CLK high. TX_DATA changes only at the start of a low phase. After the high phase of bit 18, go to TRAIL.
  - TRAIL: one full bit period with TX_DATA=0, TX_LOAD=0, TX_STOP=1. On this rising edge the receiver drops its enable; it shifts in one junk bit, which is harmless. Then go to GAP.
  - GAP: TX_CLK=0 and all outputs low for GAP_CYC cycles, then IDLE. When GAP_CYC=0, go straight to IDLE.
- The bit counter is 5 bits and counts 0..18. The half-period counter is $clog2(CLK_DIV) bits.
- RST mid-frame: on the next edge all outputs go low, the FIFO empties, the state is IDLE and the frame is abandoned. The receiver resynchronises on the next frame's TX_LOAD.

## Timing
- Reset values: P_FULL=0, OVERFLOW=0, TX_CLK=0, TX_DATA=0, TX_LOAD=0, TX_STOP=0, BUSY=0.
- Write-to-output latency:
  - P_WR sampled at edge t, into an empty FIFO in IDLE.
  - Pop occurs at edge t+1.
  - TX_DATA = frame bit 0 and BUSY=1 from edge t+2.
  - First TX_CLK rise at edge t+2+CLK_DIV.
- Frame duration: 20·2·CLK_DIV cycles in SHIFT+TRAIL, plus GAP_CYC, plus 1 cycle in IDLE before the next pop.
- TX_DATA and TX_LOAD are stable for CLK_DIV cycles before and after every TX_CLK rise.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package ser_pkg:
  - ADDR_W, DATA_W, FRAME_W.
  - State enum {IDLE, SHIFT, TRAIL, GAP}.
- One sub-module, tx_fifo (parameters WIDTH, DEPTH): synchronous single-clock FIFO with registered count, full and empty. The top level holds the FSM, dividers and shift register.

## Test plan
- Single word: write P_ADDR=5, P_DATA=16'hA5C3 (CLK_DIV=2) → TX_DATA at the 19 rises = 101_1010010111000011. TX_LOAD is high only at rise 19 and TX_STOP only at rise 20. A receiver model captures 5/A5C3.
- Back-to-back: 4 writes of addresses 0..3 → 4 frames in order, each separated by GAP_CYC+1 idle cycles. BUSY drops only after the last one.
- Overflow: 6 consecutive writes into an empty FIFO → 5 accepted (first popped at t+1). The 6th is dropped, OVERFLOW=1 and stays 1; P_FULL=1 for the cycle after the 5th write.
- CLK_DIV=1, GAP_CYC=0 → TX_CLK toggles every cycle and the frame is 40 cycles. The next frame's first bit appears 2 cycles after TRAIL ends.
- RST asserted at bit 10 of a frame with 2 words queued → next cycle all outputs are 0 and the FIFO is empty. A new write transmits a correct frame.
- Write coincident with pop while count=DEPTH-1 → accepted, count unchanged, OVERFLOW stays 0.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared field widths and transmit FSM states for the link serializer.
package ser_pkg;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 16;
  localparam int FRAME_W = ADDR_W + DATA_W;

  typedef enum logic [1:0] {IDLE, SHIFT, TRAIL, GAP} state_t;
endpackage

// File: rtl/tx_fifo.sv
// Single-clock FIFO with registered count/full/empty; writes while full are dropped.
// Read data is the head entry, valid whenever empty is low; pop takes effect at the edge.
module tx_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    count, count_n;
  logic             wr_ok, rd_ok;

  assign wr_ok = wr & ~full;
  assign rd_ok = rd & ~empty;
  assign rdata = mem[rptr];

  always_comb begin
    count_n = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      count <= count_n;
      full  <= (count_n == CW'(DEPTH));
      empty <= (count_n == '0);
    end
  end
endmodule

// File: rtl/serializer.sv
// Queues {addr,data} words and shifts each out MSB-first on a divided serial clock, with load/stop strobes.
// First bit appears two edges after the write; writes while P_FULL is high are dropped and flagged.
module serializer #(
  parameter int ADDR_W  = ser_pkg::ADDR_W,
  parameter int DATA_W  = ser_pkg::DATA_W,
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 4,
  parameter int DEPTH   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] P_ADDR,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              P_WR,
  output logic              P_FULL,
  output logic              OVERFLOW,
  output logic              TX_CLK,
  output logic              TX_DATA,
  output logic              TX_LOAD,
  output logic              TX_STOP,
  output logic              BUSY
);
  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int HC_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GC_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [HC_W-1:0] HC_LAST  = HC_W'(CLK_DIV - 1);
  localparam logic [GC_W-1:0] GAP_LAST = GC_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [4:0]      LAST_BIT = 5'(FRAME_W - 1);

  ser_pkg::state_t      state_q, state_n;
  logic [HC_W-1:0]      hcnt_q, hcnt_n;
  logic [GC_W-1:0]      gcnt_q, gcnt_n;
  logic [4:0]           bcnt_q, bcnt_n;
  logic                 phase_q, phase_n;
  logic [FRAME_W-1:0]   sreg_q, sreg_n;
  logic                 pop, fifo_full, fifo_empty;
  logic [FRAME_W-1:0]   fifo_rdata;

  tx_fifo #(.WIDTH(FRAME_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .wr    (P_WR),
    .wdata ({P_ADDR, P_DATA}),
    .rd    (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_n = state_q;
    hcnt_n  = hcnt_q;
    gcnt_n  = gcnt_q;
    bcnt_n  = bcnt_q;
    phase_n = phase_q;
    sreg_n  = sreg_q;
    pop     = 1'b0;
    case (state_q)
      ser_pkg::IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          sreg_n  = fifo_rdata;
          bcnt_n  = '0;
          hcnt_n  = '0;
          phase_n = 1'b0;
          state_n = ser_pkg::SHIFT;
        end
      end
      ser_pkg::SHIFT, ser_pkg::TRAIL: begin
        if (hcnt_q != HC_LAST) begin
          hcnt_n = hcnt_q + 1'b1;
        end else begin
          hcnt_n  = '0;
          phase_n = ~phase_q;
          // A bit period ends after its high phase; the next bit starts low.
          if (phase_q) begin
            if (state_q == ser_pkg::TRAIL) begin
              gcnt_n  = '0;
              state_n = (GAP_CYC == 0) ? ser_pkg::IDLE : ser_pkg::GAP;
            end else if (bcnt_q == LAST_BIT) begin
              state_n = ser_pkg::TRAIL;
            end else begin
              bcnt_n = bcnt_q + 1'b1;
              sreg_n = {sreg_q[FRAME_W-2:0], 1'b0};
            end
          end
        end
      end
      ser_pkg::GAP: begin
        if (gcnt_q == GAP_LAST) state_n = ser_pkg::IDLE;
        else                    gcnt_n  = gcnt_q + 1'b1;
      end
      default: state_n = ser_pkg::IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ser_pkg::IDLE;
      hcnt_q   <= '0;
      gcnt_q   <= '0;
      bcnt_q   <= '0;
      phase_q  <= 1'b0;
      sreg_q   <= '0;
      OVERFLOW <= 1'b0;
      TX_CLK   <= 1'b0;
      TX_DATA  <= 1'b0;
      TX_LOAD  <= 1'b0;
      TX_STOP  <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      state_q  <= state_n;
      hcnt_q   <= hcnt_n;
      gcnt_q   <= gcnt_n;
      bcnt_q   <= bcnt_n;
      phase_q  <= phase_n;
      sreg_q   <= sreg_n;
      OVERFLOW <= OVERFLOW | (P_WR & fifo_full);
      // Outputs trail the internal state by one edge so every pin is a flop.
      TX_CLK   <= ((state_q == ser_pkg::SHIFT) || (state_q == ser_pkg::TRAIL)) && phase_q;
      TX_DATA  <= (state_q == ser_pkg::SHIFT) && sreg_q[FRAME_W-1];
      TX_LOAD  <= (state_q == ser_pkg::SHIFT) && (bcnt_q == LAST_BIT);
      TX_STOP  <= (state_q == ser_pkg::TRAIL);
      // Stay busy through the one-cycle IDLE between queued frames.
      BUSY     <= (state_q != ser_pkg::IDLE) || (BUSY && !fifo_empty);
    end
  end

  assign P_FULL = fifo_full;
endmodule
